div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 25 ++
 rtl/div_iter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } div_state_e;

  // Number of CALC cycles needed to retire all quotient bits.
  function automatic int calc_cycles(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem, quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  // The shifted window can exceed WIDTH bits, so compare one bit wider;
  // the borrow out of the wide subtract is the "does not fit" flag.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, y_i};
  assign fits    = ~diff[WIDTH];

  assign rem_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/div_iter.sv
// Iterative signed/unsigned divider retiring BITS_PER_CYCLE quotient bits per cycle.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quo,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  output logic             busy
);

  localparam int NCYC  = calc_cycles(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(NCYC + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0 ||
      !(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
      (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_check
    $fatal(1, "div_iter: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             signed_q, signed_d;
  logic             xneg_q, xneg_d;
  logic             qneg_q, qneg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             res_dbz_q, res_dbz_d;

  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH-1:0] rem_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quo_chain [BITS_PER_CYCLE+1];

  assign x_neg = signed_q & x_q[WIDTH-1];
  assign y_neg = signed_q & y_q[WIDTH-1];
  assign x_mag = x_neg ? -x_q : x_q;
  assign y_mag = y_neg ? -y_q : y_q;

  // During CALC y_q holds |y|, so the chain divides magnitudes only.
  assign rem_chain[0] = rem_q;
  assign quo_chain[0] = quo_q;
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i (rem_chain[i]),
      .quo_i (quo_chain[i]),
      .y_i   (y_q),
      .rem_o (rem_chain[i+1]),
      .quo_o (quo_chain[i+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    signed_d  = signed_q;
    xneg_d    = xneg_q;
    qneg_d    = qneg_q;
    dbz_d     = dbz_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_dbz_d = res_dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d      = in_x;
          y_d      = in_y;
          signed_d = in_signed;
          state_d  = PREP;
        end
      end
      PREP: begin
        xneg_d = x_neg;
        qneg_d = x_neg ^ y_neg;
        y_d    = y_mag;
        if (y_q == '0) begin
          quo_d   = '1;
          rem_d   = x_q;
          dbz_d   = 1'b1;
          state_d = FIX;
        end else if (x_mag < y_mag) begin
          quo_d   = '0;
          rem_d   = x_mag;
          dbz_d   = 1'b0;
          state_d = FIX;
        end else begin
          quo_d   = x_mag;
          rem_d   = '0;
          dbz_d   = 1'b0;
          cnt_d   = CNT_W'(NCYC);
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = rem_chain[BITS_PER_CYCLE];
        quo_d = quo_chain[BITS_PER_CYCLE];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Divide-by-zero results pass through uncorrected.
        res_quo_d = (signed_q && !dbz_q && qneg_q) ? -quo_q : quo_q;
        res_rem_d = (signed_q && !dbz_q && xneg_q) ? -rem_q : rem_q;
        res_dbz_d = dbz_q;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      signed_q  <= 1'b0;
      xneg_q    <= 1'b0;
      qneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_dbz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      signed_q  <= signed_d;
      xneg_q    <= xneg_d;
      qneg_q    <= qneg_d;
      dbz_q     <= dbz_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      res_dbz_q <= res_dbz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_quo   = res_quo_q;
  assign out_rem   = res_rem_q;
  assign out_dbz   = res_dbz_q;

endmodule
